// File: rtl/fp_norm_round.sv
// Normalize-and-round stage of the FP add/sub datapath (round-to-nearest-even or truncate).
// Define FP_NORM_FAST_EN to normalize with a single leading-zero-count shift instead of 1 bit/edge.
module fp_norm_round #(
  parameter bit          ROUND_EN = 1'b1,
  parameter int unsigned EXP_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [27:0]      sig_raw_i,
  input  logic             nan_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_o,
  output logic [EXP_W-1:0] exp_o,
  output logic [26:0]      sig_untrunc_o,
  output logic             carry_o,
  output logic             nan_o
);

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StNorm,
    StRound,
    StDone
  } state_e;

  localparam logic [EXP_W-1:0] ExpMax  = '1;
  localparam logic [EXP_W-1:0] ExpOne  = EXP_W'(1);
  localparam logic [EXP_W-1:0] ExpZero = '0;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [27:0]      sig_q, sig_d;
  logic             carry_q, carry_d;
  logic             nan_q, nan_d;

  logic [EXP_W-1:0] exp_inc;
  logic             rnd_inc;
  logic [24:0]      rnd_sum;

  assign exp_inc = exp_q + ExpOne;
  assign rnd_inc = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
  assign rnd_sum = {1'b0, sig_q[26:3]} + {24'd0, rnd_inc};

`ifdef FP_NORM_FAST_EN
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && !v[i]) begin
        n = n + 5'd1;
      end else begin
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic [EXP_W-1:0] lzc_ext;
  logic [EXP_W-1:0] exp_m1;
  logic [EXP_W-1:0] shamt;
  logic             shift_limited;

  assign lzc_ext       = EXP_W'(lzc27(sig_q[26:0]));
  assign exp_m1        = exp_q - ExpOne;
  assign shift_limited = lzc_ext > exp_m1;
  assign shamt         = shift_limited ? exp_m1 : lzc_ext;
`endif

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    carry_d = carry_q;
    nan_d   = nan_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = sign_i;
          exp_d   = exp_i;
          sig_d   = sig_raw_i;
          carry_d = 1'b0;
          nan_d   = nan_i;
          state_d = nan_i ? StDone : StAlign;
        end
      end

      StAlign: begin
        if (sig_q[27]) begin
          // Bit 0 stays sticky: it absorbs the bit shifted out.
          sig_d    = {1'b0, sig_q[27:1]};
          sig_d[0] = sig_q[1] | sig_q[0];
          exp_d    = exp_inc;
        end
        if ((exp_q == ExpMax) || (sig_q[27] && (exp_inc == ExpMax))) begin
          carry_d = 1'b1;
          exp_d   = ExpMax;
          state_d = StDone;
        end else begin
          state_d = StNorm;
        end
      end

      StNorm: begin
        if (sig_q[26:0] == 27'd0) begin
          exp_d   = ExpZero;
          state_d = StRound;
        end else if (sig_q[26]) begin
          state_d = StRound;
        end else if (exp_q <= ExpOne) begin
          exp_d   = ExpZero;
          state_d = StRound;
        end else begin
`ifdef FP_NORM_FAST_EN
          // Shift is capped so the exponent never drops below 1; a capped shift is denormal.
          sig_d = {1'b0, sig_q[26:0] << shamt};
          exp_d = shift_limited ? ExpZero : (exp_q - shamt);
`else
          sig_d = {1'b0, sig_q[25:0], 1'b0};
          exp_d = exp_q - ExpOne;
`endif
        end
      end

      StRound: begin
        if (ROUND_EN) begin
          if (rnd_sum[24]) begin
            sig_d   = 28'h4000000;
            exp_d   = exp_inc;
            carry_d = (exp_inc == ExpMax);
          end else begin
            sig_d = {1'b0, rnd_sum[23:0], 3'b000};
            // A denormal that rounds up into the hidden bit becomes the smallest normal.
            if ((exp_q == ExpZero) && rnd_sum[23] && !sig_q[26]) begin
              exp_d = ExpOne;
            end
          end
        end else begin
          sig_d = {sig_q[27:3], 3'b000};
        end
        state_d = StDone;
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      exp_q   <= ExpZero;
      sig_q   <= 28'd0;
      carry_q <= 1'b0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      carry_q <= carry_d;
      nan_q   <= nan_d;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign out_valid     = (state_q == StDone);
  assign sign_o        = sign_q;
  assign exp_o         = exp_q;
  assign sig_untrunc_o = sig_q[26:0];
  assign carry_o       = carry_q;
  assign nan_o         = nan_q;

endmodule
